fan_ctrl: RTL and testbench

Multi-channel fan controller on the CPLD's I2C-mapped CSR bus: NUM_FANS PWM outputs with glitch-free duty update, per-channel tachometer RPM capture and optional stall detection with a maskable interrupt. Generalises the existing single-channel pwm/tacho pair into one parametrised block. Sits beside the other CSR peripherals, clocked by the internal oscillator, fed by the shared clockgen enables (ce_32khz, ce_1hz). Its irq output is ORed into the board interrupt line.

---
 rtl/fan_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_fan_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fan_ctrl.sv
// Multi-channel fan controller: PWM outputs with shadowed duty, tacho RPM capture and optional
// stall detection with a maskable interrupt (enabled by defining FAN_CTRL_STALL_IRQ_EN).
`timescale 1ns/1ps
module fan_ctrl #(
    parameter logic [4:0] BASE_ADDR   = 5'h0,
    parameter int         NUM_FANS    = 2,
    parameter int         STALL_LIMIT = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4:0]          csr_a,
    input  logic [7:0]          csr_di,
    input  logic                csr_we,
    output logic [7:0]          csr_do,
    input  logic                pwm_ce,
    input  logic                ce_1hz,
    input  logic [NUM_FANS-1:0] tacho_in,
    output logic [NUM_FANS-1:0] pwm_out,
    output logic [NUM_FANS-1:0] pwm_en,
    output logic                irq
);

    localparam logic [3:0] CH_MASK  = 4'((1 << NUM_FANS) - 1);
    localparam logic [4:0] LAST_OFF = 5'(1 + 2 * NUM_FANS);

    logic [5:0] diff;
    logic [4:0] off;
    logic       hit;
    logic       wr_ctrl;

    assign diff    = {1'b0, csr_a} - {1'b0, BASE_ADDR};
    assign off     = diff[4:0];
    assign hit     = !diff[5] && (off <= LAST_OFF);
    assign wr_ctrl = csr_we && hit && (off == 5'd0);

    logic [3:0] en_q;
    logic [3:0] inv_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q  <= '0;
            inv_q <= '0;
        end else if (wr_ctrl) begin
            en_q  <= csr_di[3:0] & CH_MASK;
            inv_q <= csr_di[7:4] & CH_MASK;
        end
    end

    assign pwm_en = en_q[NUM_FANS-1:0];

    logic [7:0] pwm_cnt;
    logic       wrap;

    assign wrap = pwm_ce && (pwm_cnt == 8'hFF);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else if (pwm_ce) begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    logic [NUM_FANS-1:0][7:0] duty_v;
    logic [NUM_FANS-1:0][7:0] tacho_v;
    logic [3:0]               stall_set;

    for (genvar g = 0; g < NUM_FANS; g++) begin : g_ch
        logic [7:0] duty;
        logic [7:0] shadow;
        logic       run;
        logic       raw;
        logic [1:0] sync;
        logic       prev;
        logic       edge_det;
        logic [7:0] tcnt;
        logic [7:0] tcap;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                duty <= '0;
            end else if (csr_we && hit && (off == 5'(2 + 2 * g))) begin
                duty <= csr_di;
            end
        end

        // run gates the output until the first wrap after enable, so a period never starts mid-count
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                shadow <= '0;
                run    <= 1'b0;
            end else if (!en_q[g]) begin
                shadow <= duty;
                run    <= 1'b0;
            end else if (wrap) begin
                shadow <= duty;
                run    <= 1'b1;
            end
        end

        assign raw        = run && (pwm_cnt < shadow);
        assign pwm_out[g] = en_q[g] ? (raw ^ inv_q[g]) : inv_q[g];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync <= '0;
                prev <= 1'b0;
                tcnt <= '0;
                tcap <= '0;
            end else begin
                sync <= {sync[0], tacho_in[g]};
                prev <= sync[1];
                if (ce_1hz) begin
                    tcap <= tcnt;
                    tcnt <= {7'd0, edge_det};
                end else if (edge_det && (tcnt != 8'hFF)) begin
                    tcnt <= tcnt + 8'd1;
                end
            end
        end

        assign edge_det   = sync[1] & ~prev;
        assign duty_v[g]  = duty;
        assign tacho_v[g] = tcap;

`ifdef FAN_CTRL_STALL_IRQ_EN
        localparam logic [2:0] STALL_LIM = 3'(STALL_LIMIT);
        logic [2:0] sc;
        logic       qual;

        // qualifies on the count being captured by this ce_1hz
        assign qual = en_q[g] && (duty != 8'd0) && (tcnt == 8'd0);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sc <= '0;
            end else if (ce_1hz) begin
                if (!qual) begin
                    sc <= '0;
                end else if (sc != STALL_LIM) begin
                    sc <= sc + 3'd1;
                end
            end
        end

        assign stall_set[g] = ce_1hz && qual && (sc >= STALL_LIM - 3'd1);
`else
        assign stall_set[g] = 1'b0;
`endif
    end

    for (genvar g = NUM_FANS; g < 4; g++) begin : g_pad
        assign stall_set[g] = 1'b0;
    end

    logic [7:0] status_rd;

`ifdef FAN_CTRL_STALL_IRQ_EN
    logic [3:0] flags;
    logic [3:0] irq_en;
    logic       wr_status;

    assign wr_status = csr_we && hit && (off == 5'd1);

    // a stall set in the same cycle as a W1C clear wins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags  <= '0;
            irq_en <= '0;
        end else begin
            if (wr_status) begin
                irq_en <= csr_di[7:4] & CH_MASK;
            end
            flags <= (flags & ~(wr_status ? csr_di[3:0] : 4'h0)) | stall_set;
        end
    end

    assign status_rd = {irq_en, flags};
    assign irq       = |(flags & irq_en);
`else
    assign status_rd = 8'h00;
    assign irq       = 1'b0;
`endif

    always_comb begin
        csr_do = '0;
        if (hit) begin
            if (off == 5'd0) begin
                csr_do = {inv_q, en_q};
            end else if (off == 5'd1) begin
                csr_do = status_rd | {4'h0, stall_set & 4'h0};
            end else begin
                for (int unsigned i = 0; i < NUM_FANS; i++) begin
                    if (off == 5'(2 + 2 * i)) csr_do = duty_v[i];
                    if (off == 5'(3 + 2 * i)) csr_do = tacho_v[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_fan_ctrl.sv
// Scoreboard bench for fan_ctrl: expectations are queued with stimulus and popped at sampling.
`timescale 1ns/1ps
module tb_fan_ctrl;

    localparam int NF = 2;

`ifdef FAN_CTRL_STALL_IRQ_EN
    localparam bit HAS_STALL = 1'b1;
`else
    localparam bit HAS_STALL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    csr_a;
    logic [7:0]    csr_di;
    logic          csr_we;
    logic [7:0]    csr_do;
    logic          pwm_ce;
    logic          ce_1hz;
    logic [NF-1:0] tacho_in;
    logic [NF-1:0] pwm_out;
    logic [NF-1:0] pwm_en;
    logic          irq;

    always #5 clk = ~clk;

    fan_ctrl #(.BASE_ADDR(5'h0), .NUM_FANS(NF), .STALL_LIMIT(3)) dut (
        .clk(clk), .rst_n(rst_n), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
        .csr_do(csr_do), .pwm_ce(pwm_ce), .ce_1hz(ce_1hz), .tacho_in(tacho_in),
        .pwm_out(pwm_out), .pwm_en(pwm_en), .irq(irq)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pop_exp();
        if (sb_q.size() == 0) return 32'hFFFF_FFFF;
        return sb_q.pop_front();
    endfunction

    task automatic csr_wr(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        csr_a = a; csr_di = d; csr_we = 1'b1;
        @(negedge clk);
        csr_we = 1'b0;
    endtask

    task automatic csr_rd(input logic [4:0] a, output logic [7:0] d);
        @(negedge clk);
        csr_a = a;
        #1 d = csr_do;
    endtask

    task automatic ce_pulse();
        @(negedge clk);
        ce_1hz = 1'b1;
        @(negedge clk);
        ce_1hz = 1'b0;
    endtask

    task automatic tacho_pulses(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); tacho_in[ch] = 1'b1;
            repeat (2) @(negedge clk);
            tacho_in[ch] = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic run_period(input int n, input int wr_at, input logic [7:0] wr_d,
                              output int h0, output int h1);
        h0 = 0; h1 = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
            if (i == wr_at) begin
                csr_a = 5'd2; csr_di = wr_d; csr_we = 1'b1;
            end else begin
                csr_we = 1'b0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        int h0, h1;
        rst_n = 1'b0; csr_a = '0; csr_di = '0; csr_we = 1'b0;
        pwm_ce = 1'b0; ce_1hz = 1'b0; tacho_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a < 7; a++) begin
            sb_q.push_back(32'h0);
            csr_rd(5'(a), d);
            check($sformatf("reset_rd%0d", a), {24'h0, d}, pop_exp());
        end
        sb_q.push_back(32'h0); check("reset_pwm_out", {30'h0, pwm_out}, pop_exp());
        sb_q.push_back(32'h0); check("reset_pwm_en", {30'h0, pwm_en}, pop_exp());
        sb_q.push_back(32'h0); check("reset_irq", {31'h0, irq}, pop_exp());

        csr_wr(5'd0, 8'hFF);
        sb_q.push_back(32'h33); csr_rd(5'd0, d); check("ctrl_mask", {24'h0, d}, pop_exp());
        csr_wr(5'd0, 8'h01);
        sb_q.push_back(32'h01); csr_rd(5'd0, d); check("ctrl_rd", {24'h0, d}, pop_exp());
        sb_q.push_back(32'h1); check("pwm_en", {30'h0, pwm_en}, pop_exp());
        csr_wr(5'd2, 8'h40);
        sb_q.push_back(32'h40); csr_rd(5'd2, d); check("duty0_rd", {24'h0, d}, pop_exp());

        // counter is 0 here; the first 255 pwm_ce precede the first wrap
        @(negedge clk);
        pwm_ce = 1'b1;
        sb_q.push_back(32'd0); sb_q.push_back(32'd0);
        run_period(255, -1, 8'h00, h0, h1);
        check("pre_wrap_high0", h0, pop_exp()); check("pre_wrap_high1", h1, pop_exp());
        sb_q.push_back(32'd64); sb_q.push_back(32'd0);
        run_period(256, -1, 8'h00, h0, h1);
        check("duty40_high0", h0, pop_exp()); check("duty40_high1", h1, pop_exp());
        sb_q.push_back(32'd64);
        run_period(256, 100, 8'hC0, h0, h1);
        check("midwrite_high0", h0, pop_exp());
        sb_q.push_back(32'd192);
        run_period(256, -1, 8'h00, h0, h1);
        check("dutyC0_high0", h0, pop_exp());
        pwm_ce = 1'b0;

        csr_wr(5'd0, 8'h21);
        sb_q.push_back(32'h1); check("invert_disabled", {31'h0, pwm_out[1]}, pop_exp());
        csr_wr(5'd0, 8'h00);

        ce_pulse();
        tacho_pulses(1, 37);
        ce_pulse();
        sb_q.push_back(32'd37); csr_rd(5'd5, d); check("tacho1_37", {24'h0, d}, pop_exp());
        sb_q.push_back(32'd0);  csr_rd(5'd3, d); check("tacho0_0", {24'h0, d}, pop_exp());
        tacho_pulses(1, 300);
        ce_pulse();
        sb_q.push_back(32'd255); csr_rd(5'd5, d); check("tacho1_sat", {24'h0, d}, pop_exp());

        csr_wr(5'd0, 8'h01);
        csr_wr(5'd2, 8'h80);
        csr_wr(5'd1, 8'h10);
        ce_pulse(); ce_pulse();
        sb_q.push_back(HAS_STALL ? 32'h10 : 32'h0); csr_rd(5'd1, d); check("stall_2nd", {24'h0, d}, pop_exp());
        sb_q.push_back(32'h0); check("irq_2nd", {31'h0, irq}, pop_exp());
        ce_pulse();
        sb_q.push_back(HAS_STALL ? 32'h11 : 32'h0); csr_rd(5'd1, d); check("stall_3rd", {24'h0, d}, pop_exp());
        sb_q.push_back({31'h0, HAS_STALL}); check("irq_3rd", {31'h0, irq}, pop_exp());
        csr_wr(5'd1, 8'h11);
        sb_q.push_back(HAS_STALL ? 32'h10 : 32'h0); csr_rd(5'd1, d); check("stall_w1c", {24'h0, d}, pop_exp());
        sb_q.push_back(32'h0); check("irq_w1c", {31'h0, irq}, pop_exp());

        csr_wr(5'd0, 8'h00);
        ce_pulse();
        csr_wr(5'd0, 8'h01);
        ce_pulse(); ce_pulse();
        sb_q.push_back(HAS_STALL ? 32'h10 : 32'h0); csr_rd(5'd1, d); check("stall_rearm", {24'h0, d}, pop_exp());
        @(negedge clk);
        csr_a = 5'd1; csr_di = 8'h11; csr_we = 1'b1; ce_1hz = 1'b1;
        @(negedge clk);
        csr_we = 1'b0; ce_1hz = 1'b0;
        sb_q.push_back(HAS_STALL ? 32'h11 : 32'h0); csr_rd(5'd1, d); check("stall_set_wins", {24'h0, d}, pop_exp());
        sb_q.push_back({31'h0, HAS_STALL}); check("irq_set_wins", {31'h0, irq}, pop_exp());

        csr_wr(5'd0, 8'h23);
        @(negedge clk);
        pwm_ce = 1'b1;
        repeat (10) @(negedge clk);
        sb_q.push_back(32'h3); check("run_both", {30'h0, pwm_out}, pop_exp());
        rst_n = 1'b0;
        @(negedge clk);
        pwm_ce = 1'b0;
        sb_q.push_back(32'h0); check("midrst_pwm_out", {30'h0, pwm_out}, pop_exp());
        sb_q.push_back(32'h0); check("midrst_pwm_en", {30'h0, pwm_en}, pop_exp());
        sb_q.push_back(32'h0); check("midrst_irq", {31'h0, irq}, pop_exp());
        rst_n = 1'b1;
        sb_q.push_back(32'h0); csr_rd(5'd0, d); check("midrst_ctrl", {24'h0, d}, pop_exp());
        sb_q.push_back(32'h0); csr_rd(5'd2, d); check("midrst_duty0", {24'h0, d}, pop_exp());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
